// File: rtl/top_top.sv
// -----------------------------------------------------------------------------
// flog_pkg / top_top
//
// Pipelined bfloat16 log2 unit. Every valid operand produces one rounded
// (nearest, ties to even) bfloat16 result exactly three cycles after the edge
// that sampled it. A new operand may be accepted on every cycle.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous reset, active low
//   sign       : operand sign
//   exponent   : operand biased exponent (bias 127)
//   fractional : operand fraction without the hidden bit
//   valid_i    : operand valid
//   s_res_o    : result sign
//   e_res_o    : result biased exponent
//   f_res_o    : result fraction
//   valid_o    : one-cycle pulse per accepted operand
//
// Build option
//   FLOG_SUBNORMAL_EN : when defined, subnormal operands are normalised and
//                       processed; otherwise they are flushed to zero (-inf).
//
// Pipeline
//   s1 : classify operand, form unbiased exponent and table index
//   s2 : registered table read of log2(1.f)
//   s3 : signed fixed-point sum, magnitude, leading-one normalise
//   s4 : round to nearest even, substitute special results
// -----------------------------------------------------------------------------
package flog_pkg;
  localparam int EXP_WIDTH   = 8;
  localparam int FRACT_WIDTH = 7;
  localparam int S_WIDTH     = 1;
endpackage

module top_top
  import flog_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [S_WIDTH-1:0]     sign,
  input  logic [EXP_WIDTH-1:0]   exponent,
  input  logic [FRACT_WIDTH-1:0] fractional,
  input  logic                   valid_i,
  output logic [S_WIDTH-1:0]     s_res_o,
  output logic [EXP_WIDTH-1:0]   e_res_o,
  output logic [FRACT_WIDTH-1:0] f_res_o,
  output logic                   valid_o
);

  // Table fraction bits; wide enough that the rounding decision is made
  // well below the last kept bit of the smallest results.
  localparam int LUT_FW = 40;
  // Magnitude: 8 integer bits (|log2| <= 133) plus the table fraction.
  localparam int MAG_W  = 8 + LUT_FW;
  localparam int SUM_W  = MAG_W + 1;
  localparam int LUT_N  = 1 << FRACT_WIDTH;

  typedef enum logic [2:0] {
    SP_NORM,
    SP_ZERO,
    SP_NINF,
    SP_PINF,
    SP_QNAN
  } special_t;

  // log2(1 + k/128) as an unsigned fraction, by repeated squaring: each
  // squaring doubles the log, and an overflow past 2.0 yields the next bit.
  // The mantissa is held as Q2.62 so truncation stays far below LUT_FW bits.
  function automatic logic [LUT_FW-1:0] log2_frac(input int k);
    logic [127:0]      m;
    logic [LUT_FW-1:0] r;
    m = 128'(LUT_N + k) << (62 - FRACT_WIDTH);
    r = '0;
    for (int i = 0; i < LUT_FW; i++) begin
      m = (m * m) >> 62;
      r = {r[LUT_FW-2:0], 1'b0};
      if (m >= (128'd1 << 63)) begin
        r[0] = 1'b1;
        m    = m >> 1;
      end
    end
    return r;
  endfunction

  logic [LUT_FW-1:0] lut [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam logic [LUT_FW-1:0] LUT_VAL = log2_frac(gi);
    assign lut[gi] = LUT_VAL;
  end

  // ---------------------------------------------------------------- s1 decode
  special_t                dec_special;
  logic signed [8:0]       dec_eunb;
  logic [FRACT_WIDTH-1:0]  dec_idx;

`ifdef FLOG_SUBNORMAL_EN
  logic [2:0]             sub_lead;
  logic [FRACT_WIDTH-1:0] sub_frac;

  // Leading one of a subnormal fraction; the bits below it become the
  // fraction of the normalised mantissa.
  always_comb begin
    sub_lead = '0;
    for (int i = 0; i < FRACT_WIDTH; i++) begin
      if (fractional[i]) sub_lead = 3'(i);
    end
    sub_frac = fractional << (3'd7 - sub_lead);
  end
`endif

  always_comb begin
    dec_special = SP_NORM;
    dec_eunb    = '0;
    dec_idx     = fractional;
    if (exponent == '1) begin
      dec_special = ((fractional != '0) || sign[0]) ? SP_QNAN : SP_PINF;
    end else if (exponent == '0) begin
      if (fractional == '0) begin
        dec_special = SP_NINF;
      end else begin
`ifdef FLOG_SUBNORMAL_EN
        if (sign[0]) begin
          dec_special = SP_QNAN;
        end else begin
          // 0.f * 2^-126 = 1.rest * 2^(lead - 133)
          dec_eunb = $signed({6'b0, sub_lead}) - 9'sd133;
          dec_idx  = sub_frac;
        end
`else
        dec_special = SP_NINF;
`endif
      end
    end else if (sign[0]) begin
      dec_special = SP_QNAN;
    end else if ((exponent == 8'd127) && (fractional == '0)) begin
      // Exact zero result; the normaliser has no leading one to find.
      dec_special = SP_ZERO;
    end else begin
      dec_eunb = $signed({1'b0, exponent}) - 9'sd127;
    end
  end

  logic                   v1_reg, v2_reg, v3_reg;
  special_t               sp1_reg, sp2_reg, sp3_reg;
  logic signed [8:0]      eunb1_reg, eunb2_reg;
  logic [FRACT_WIDTH-1:0] idx1_reg;
  logic [LUT_FW-1:0]      lut_q_reg;
  logic                   neg3_reg;
  logic [7:0]             exp3_reg;
  logic [6:0]             frac3_reg;
  logic                   guard3_reg;
  logic                   sticky3_reg;

  // ------------------------------------------------------------- s2 table read
  always_ff @(posedge clk) begin
    lut_q_reg <= lut[idx1_reg];
  end

  // ------------------------------------------------------ s3 sum and normalise
  logic [SUM_W-1:0] sum;
  logic             sum_neg;
  logic [MAG_W-1:0] mag;
  logic [5:0]       lead;
  logic [5:0]       shamt;
  logic [MAG_W-2:0] norm;

  always_comb begin
    // eunb * 2^LUT_FW in two's complement plus the positive table fraction
    sum     = {eunb2_reg, {LUT_FW{1'b0}}} + {{(SUM_W-LUT_FW){1'b0}}, lut_q_reg};
    sum_neg = sum[SUM_W-1];
    mag     = sum_neg ? MAG_W'(-sum) : sum[MAG_W-1:0];
    lead    = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag[i]) lead = 6'(i);
    end
    shamt = 6'(MAG_W - 1) - lead;
    // The leading one lands on the dropped top bit; keep what lies below it.
    norm  = (MAG_W-1)'(mag << shamt);
  end

  // ------------------------------------------------------------ s4 round, out
  logic [7:0] frac_sum;
  logic [7:0] exp_rnd;
  logic       rnd_up;
  logic       res_s;
  logic [7:0] res_e;
  logic [6:0] res_f;

  always_comb begin
    rnd_up   = guard3_reg & (sticky3_reg | frac3_reg[0]);
    frac_sum = {1'b0, frac3_reg} + {7'b0, rnd_up};
    // A carry out of the fraction bumps the exponent; fraction wraps to 0.
    exp_rnd  = exp3_reg + {7'b0, frac_sum[7]};
    res_s    = 1'b0;
    res_e    = '0;
    res_f    = '0;
    case (sp3_reg)
      SP_NORM: begin
        res_s = neg3_reg;
        res_e = exp_rnd;
        res_f = frac_sum[6:0];
      end
      SP_NINF: begin
        res_s = 1'b1;
        res_e = 8'hFF;
      end
      SP_PINF: begin
        res_e = 8'hFF;
      end
      SP_QNAN: begin
        res_e = 8'hFF;
        res_f = 7'b1000000;
      end
      default: begin
        res_s = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_reg      <= 1'b0;
      sp1_reg     <= SP_NORM;
      eunb1_reg   <= '0;
      idx1_reg    <= '0;
      v2_reg      <= 1'b0;
      sp2_reg     <= SP_NORM;
      eunb2_reg   <= '0;
      v3_reg      <= 1'b0;
      sp3_reg     <= SP_NORM;
      neg3_reg    <= 1'b0;
      exp3_reg    <= '0;
      frac3_reg   <= '0;
      guard3_reg  <= 1'b0;
      sticky3_reg <= 1'b0;
      valid_o     <= 1'b0;
      s_res_o     <= '0;
      e_res_o     <= '0;
      f_res_o     <= '0;
    end else begin
      v1_reg      <= valid_i;
      sp1_reg     <= dec_special;
      eunb1_reg   <= dec_eunb;
      idx1_reg    <= dec_idx;

      v2_reg      <= v1_reg;
      sp2_reg     <= sp1_reg;
      eunb2_reg   <= eunb1_reg;

      v3_reg      <= v2_reg;
      sp3_reg     <= sp2_reg;
      neg3_reg    <= sum_neg;
      exp3_reg    <= 8'(lead) + 8'(127 - LUT_FW);
      frac3_reg   <= norm[MAG_W-2 -: 7];
      guard3_reg  <= norm[MAG_W-9];
      sticky3_reg <= |norm[MAG_W-10:0];

      valid_o     <= v3_reg;
      // Result ports hold their last value between pulses.
      if (v3_reg) begin
        s_res_o <= res_s;
        e_res_o <= res_e;
        f_res_o <= res_f;
      end
    end
  end

endmodule

// File: tb/tb_top_top.sv
// -----------------------------------------------------------------------------
// tb_top_top
//
// Drives directed and random bfloat16 operands into top_top and compares each
// cycle's outputs with a real-arithmetic log2 reference rounded to bfloat16.
// Build with or without FLOG_SUBNORMAL_EN to match the design build.
// -----------------------------------------------------------------------------
module tb_top_top;

  logic       clk;
  logic       rst;
  logic [0:0] sign;
  logic [7:0] exponent;
  logic [6:0] fractional;
  logic       valid_i;
  logic [0:0] s_res_o;
  logic [7:0] e_res_o;
  logic [6:0] f_res_o;
  logic       valid_o;

  top_top dut (
    .clk        (clk),
    .rst        (rst),
    .sign       (sign),
    .exponent   (exponent),
    .fractional (fractional),
    .valid_i    (valid_i),
    .s_res_o    (s_res_o),
    .e_res_o    (e_res_o),
    .f_res_o    (f_res_o),
    .valid_o    (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [15:0] op;
    logic [15:0] res;
  } txn_t;

  txn_t        pend[$];
  logic [15:0] last_res;
  int          n_vec;
  int          n_err;

  localparam logic [15:0] NINF = {1'b1, 8'hFF, 7'h00};
  localparam logic [15:0] PINF = {1'b0, 8'hFF, 7'h00};
  localparam logic [15:0] QNAN = {1'b0, 8'hFF, 7'b1000000};

  function automatic logic [15:0] bf(input logic s, input logic [7:0] e, input logic [6:0] f);
    return {s, e, f};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  // Round a real to bfloat16, nearest with ties to even.
  function automatic logic [15:0] to_bf16(input real r);
    real  a;
    real  sc;
    real  rem;
    int   e2;
    int   q;
    logic s;
    if (r == 0.0) return 16'h0000;
    s  = (r < 0.0);
    a  = s ? -r : r;
    e2 = 0;
    while (a >= 2.0) begin a = a / 2.0; e2++; end
    while (a < 1.0)  begin a = a * 2.0; e2--; end
    sc  = (a - 1.0) * 128.0;
    q   = $rtoi(sc);
    rem = sc - real'(q);
    if (rem > 0.5 || (rem == 0.5 && q[0])) q++;
    if (q == 128) begin q = 0; e2++; end
    return {s, 8'(e2 + 127), 7'(q)};
  endfunction

  function automatic logic [15:0] ref_log2(input logic [15:0] op);
    logic       s;
    logic [7:0] e;
    logic [6:0] f;
    real        lg;
    s = op[15];
    e = op[14:7];
    f = op[6:0];
    if (e == 8'hFF) return (f != 0 || s) ? QNAN : PINF;
    if (e == 8'h00 && f == 0) return NINF;
    if (e == 8'h00) begin
`ifdef FLOG_SUBNORMAL_EN
      if (s) return QNAN;
      lg = -126.0 + $ln(real'(f) / 128.0) / $ln(2.0);
`else
      return NINF;
`endif
    end else begin
      if (s) return QNAN;
      lg = real'(e) - 127.0 + $ln(1.0 + real'(f) / 128.0) / $ln(2.0);
    end
    return to_bf16(lg);
  endfunction

  function automatic logic [15:0] dut_res();
    return {s_res_o, e_res_o, f_res_o};
  endfunction

  task automatic model_flush();
    pend.delete();
    for (int i = 0; i < 3; i++) pend.push_back('{1'b0, 16'h0, 16'h0});
    last_res = 16'h0;
  endtask

  // One clock: apply inputs, let the edge sample them, then check the output
  // that belongs to the operand sampled three edges earlier.
  task automatic cycle(input logic v, input logic [15:0] op, input logic [15:0] exp_res);
    txn_t t;
    sign       = op[15];
    exponent   = op[14:7];
    fractional = op[6:0];
    valid_i    = v;
    @(posedge clk);
    #1;
    pend.push_back('{v, op, exp_res});
    if (pend.size() > 3) begin
      t = pend.pop_front();
      check_eq("valid_o", 16'(valid_o), 16'(t.v));
      if (t.v) begin
        check_eq("result", dut_res(), t.res);
        last_res = t.res;
        $display("txn op=%h res=%h exp=%h", t.op, dut_res(), t.res);
      end else begin
        check_eq("hold", dut_res(), last_res);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 16'h0);
  endtask

  initial begin
    logic [15:0] op;
    logic        v;
    int          n_ops;
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b0;
    sign       = '0;
    exponent   = '0;
    fractional = '0;
    valid_i    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 16'(valid_o), 16'h0);
    check_eq("rst_res", dut_res(), 16'h0);
    rst = 1'b1;
    model_flush();

    // Directed values
    cycle(1'b1, bf(0, 8'd127, 7'b1111010), bf(0, 8'b01111110, 7'b1110111));
    cycle(1'b1, bf(0, 8'd143, 7'b1111010), bf(0, 8'b10000011, 7'b0001000));
    cycle(1'b1, bf(0, 8'd128, 7'b0000000), bf(0, 8'd127, 7'b0000000));
    cycle(1'b1, bf(0, 8'd127, 7'b0000000), bf(0, 8'd0, 7'b0000000));
    cycle(1'b1, bf(0, 8'd0,   7'b0000000), NINF);
    cycle(1'b1, bf(1, 8'd0,   7'b0000000), NINF);
    cycle(1'b1, bf(0, 8'd255, 7'b0000000), PINF);
    cycle(1'b1, bf(1, 8'd130, 7'b0010000), QNAN);
    cycle(1'b1, bf(0, 8'd255, 7'b0000001), QNAN);
    cycle(1'b1, bf(1, 8'd255, 7'b0000000), QNAN);
    cycle(1'b1, bf(0, 8'd126, 7'b0000000), bf(1, 8'd127, 7'b0000000));
`ifdef FLOG_SUBNORMAL_EN
    cycle(1'b1, bf(0, 8'd0, 7'b1000000), bf(1, 8'b10000101, 7'b1111110));
`else
    cycle(1'b1, bf(0, 8'd0, 7'b1000000), NINF);
`endif
    idle(5);

    // Back-to-back stream, then reset while operands are in flight
    for (int i = 0; i < 7; i++) begin
      op = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
      cycle(1'b1, op, ref_log2(op));
    end
    #2;
    rst     = 1'b0;
    valid_i = 1'b0;
    #1;
    check_eq("mid_rst_valid", 16'(valid_o), 16'h0);
    check_eq("mid_rst_res", dut_res(), 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_flush();
    idle(6);

    // Random positive operands with random idle gaps
    n_ops = 0;
    while (n_ops < 10000) begin
      v  = ($urandom_range(0, 4) != 0);
      op = {1'b0, 8'($urandom_range(0, 255)), 7'($urandom)};
      cycle(v, op, ref_log2(op));
      if (v) n_ops++;
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/top_top.md
TOP_TOP -- requirements
Module: top_top

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (asserted when 0).
REQ-003 SHALL have port sign, input, 1, bfloat16 operand sign.
REQ-004 SHALL have port exponent, input, 8 (EXP_WIDTH), operand biased exponent (bias 127).
REQ-005 SHALL have port fractional, input, 7 (FRACT_WIDTH), operand fraction without hidden bit.
REQ-006 SHALL have port valid_i, input, 1, operand valid, sampled every rising clk edge.
REQ-007 SHALL have port s_res_o, output, 1, result sign.
REQ-008 SHALL have port e_res_o, output, 8, result biased exponent.
REQ-009 SHALL have port f_res_o, output, 7, result fraction.
REQ-010 SHALL have port valid_o, output, 1, result valid, one-cycle pulse per accepted operand.
REQ-011 SHALL take EXP_WIDTH=8, FRACT_WIDTH=7, S_WIDTH=1 from flog_pkg; no module parameters.

Function
REQ-012 SHALL compute bfloat16 result = log2(operand), rounded to nearest, ties to even, from the exact value.
REQ-013 SHALL compute log2 as (exponent-127) + log2(1.fraction), using a 128-entry table of log2(1.f) with at least 24 fraction bits.
REQ-014 SHALL normalise the signed fixed-point sum with a leading-zero count, then round.
REQ-015 SHALL produce a negative result as sign=1 with a magnitude field.
REQ-016 SHALL map operand 1.0 (0,127,0) to +0 (0,0,0).
REQ-017 SHALL map +0/-0 (exponent 0, fraction 0) to -inf (1,255,0).
REQ-018 SHALL map +inf (0,255,0) to +inf (0,255,0).
REQ-019 SHALL map NaN (exponent 255, fraction≠0) to qNaN (0,255,1000000).
REQ-020 SHALL map any negative nonzero non-NaN operand, including -inf, to qNaN (0,255,1000000).
REQ-021 SHALL be fully pipelined with latency 3: an operand sampled with valid_i=1 at edge N yields valid_o=1 plus its result after edge N+3.
REQ-022 SHALL accept a new operand every cycle; back-to-back results SHALL emerge in order.
REQ-023 SHALL hold the last result on s_res_o/e_res_o/f_res_o while valid_o=0.
REQ-024 SHALL ignore operand inputs when valid_i=0 and generate no valid_o for that cycle.

Reset
REQ-025 SHALL, while rst=0, force valid_o=0, s_res_o=0, e_res_o=0, f_res_o=0 and clear all pipeline valid bits, asynchronously.
REQ-026 SHALL discard operands in flight when reset is asserted mid-operation; no valid_o for them after release.
REQ-027 SHALL sample the first operand at the first rising edge with rst=1.

Configuration
REQ-028 SHALL, with macro FLOG_SUBNORMAL_EN defined, treat exponent 0 with fraction≠0 as a subnormal: value 0.f·2^-126, log2 computed from the normalised mantissa, e.g. (0,0,1000000) -> -127 = (1,10000101,1111110).
REQ-029 SHALL, without FLOG_SUBNORMAL_EN, flush subnormal operands to zero, yielding -inf (1,255,0).

Verification
REQ-030 SHALL check (0,127,1111010) [1.953125] -> (0,01111110,1110111) 3 cycles after valid_i.
REQ-031 SHALL check (0,143,1111010) -> (0,10000011,0001000); (0,128,0) [2.0] -> (0,127,0); (0,127,0) -> (0,0,0).
REQ-032 SHALL check specials: (0,0,0) -> (1,255,0); (0,255,0) -> (0,255,0); (1,130,0010000) -> (0,255,1000000); (0,255,0000001) -> (0,255,1000000).
REQ-033 SHALL check 4 back-to-back operands give 4 consecutive valid_o pulses in order, then assert rst=0 mid-stream -> no further valid_o.
REQ-034 SHALL check 10^4 random positive operands against a C log2f reference rounded to bfloat16 (RNE) with zero mismatches, in both macro settings.
